// File: rtl/miinst_queue_pkg.sv
// Shared micro-instruction types and default sizing for the micro-instruction queue.
// The MIQ_* macros may be predefined on the command line to resize every user at once.
`ifndef MIQ_FET_W
`define MIQ_FET_W 4
`endif
`ifndef MIQ_DEPTH
`define MIQ_DEPTH 16
`endif
`ifndef MIQ_DEQ_W
`define MIQ_DEQ_W 2
`endif
`define MIQ_FET_W_W $clog2(`MIQ_FET_W)
`define MIQ_DEPTH_W $clog2(`MIQ_DEPTH)
`define MIQ_DEQ_W_W $clog2(`MIQ_DEQ_W)

package miinst_queue_pkg;

  typedef enum logic [3:0] {
    MIOP_NOP = 4'd0,
    MIOP_ALU = 4'd1,
    MIOP_LD  = 4'd2,
    MIOP_ST  = 4'd3,
    MIOP_BR  = 4'd4,
    MIOP_MUL = 4'd5
  } miop_e;

  typedef struct packed {
    miop_e       opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } miinst_t;

  localparam int MIQ_FET_W   = `MIQ_FET_W;
  localparam int MIQ_DEPTH   = `MIQ_DEPTH;
  localparam int MIQ_DEQ_W   = `MIQ_DEQ_W;
  localparam int MIQ_FET_W_W = `MIQ_FET_W_W;
  localparam int MIQ_DEPTH_W = `MIQ_DEPTH_W;
  localparam int MIQ_DEQ_W_W = `MIQ_DEQ_W_W;

  function automatic miinst_t miinst_nop();
    miinst_t n;
    n.opcode = MIOP_NOP;
    n.rd     = '0;
    n.rs1    = '0;
    n.rs2    = '0;
    n.imm    = '0;
    return n;
  endfunction

endpackage

// File: rtl/miinst_queue_if.sv
// Fetch-side and issue-side handshake of the micro-instruction queue.
// master = fetch producer plus issue consumer; slave = the queue itself.
interface miinst_queue_if
  import miinst_queue_pkg::*;
#(
  parameter int FET_W = MIQ_FET_W,
  parameter int DEPTH = MIQ_DEPTH,
  parameter int DEQ_W = MIQ_DEQ_W
);
  localparam int POP_W = $clog2(DEQ_W + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  miinst_t [FET_W-1:0] fet_miinst;
  logic                fet_valid;
  logic                fet_ready;
  miinst_t [DEQ_W-1:0] deq_miinst;
  logic [DEQ_W-1:0]    deq_valid;
  logic [POP_W-1:0]    deq_pop;
  logic [CNT_W-1:0]    count;
  logic                empty;
  logic                full;

  modport master (
    output fet_miinst, fet_valid, deq_pop,
    input  fet_ready, deq_miinst, deq_valid, count, empty, full
  );

  modport slave (
    input  fet_miinst, fet_valid, deq_pop,
    output fet_ready, deq_miinst, deq_valid, count, empty, full
  );
endinterface

// File: rtl/miinst_queue_compactor.sv
// Squeezes the NOP slots out of a fetch bundle, keeping slot order, and counts the survivors.
module miinst_compactor
  import miinst_queue_pkg::*;
#(
  parameter int FET_W = MIQ_FET_W
) (
  input  miinst_t [FET_W-1:0]          fet_miinst,
  output miinst_t [FET_W-1:0]          compacted,
  output logic [$clog2(FET_W+1)-1:0]   n_in
);
  localparam int NIN_W = $clog2(FET_W + 1);

  logic [FET_W-1:0] live;
  logic [NIN_W-1:0] pos [FET_W];
  logic [NIN_W-1:0] run;

  // Exclusive prefix popcount: pos[j] is the compacted slot a live entry j lands in.
  always_comb begin
    live = '0;
    run  = '0;
    for (int j = 0; j < FET_W; j++) begin
      live[j] = (fet_miinst[j].opcode != MIOP_NOP);
      pos[j]  = run;
      run     = run + NIN_W'(live[j]);
    end
  end

  assign n_in = run;

  always_comb begin
    for (int k = 0; k < FET_W; k++) begin
      compacted[k] = miinst_nop();
      for (int j = k; j < FET_W; j++) begin
        if (live[j] && (pos[j] == NIN_W'(k))) compacted[k] = fet_miinst[j];
      end
    end
  end

endmodule

// File: rtl/miinst_queue.sv
// Circular micro-instruction queue between micro-decode and issue: NOP-compacting
// multi-slot push, up to DEQ_W oldest entries presented and poppable per cycle.
module miinst_queue
  import miinst_queue_pkg::*;
#(
  parameter int FET_W = MIQ_FET_W,
  parameter int DEPTH = MIQ_DEPTH,
  parameter int DEQ_W = MIQ_DEQ_W
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  miinst_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int POP_W = $clog2(DEQ_W + 1);
  localparam int NIN_W = $clog2(FET_W + 1);

  miinst_t          mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  miinst_t [FET_W-1:0] compacted_p0;
  logic [NIN_W-1:0]    n_in_p0;
  logic                vld_p0;
  logic                fet_ready;
  logic [POP_W-1:0]    eff_pop;
  logic [CNT_W-1:0]    count_next;

  // A pop request larger than the occupancy is clamped to what is actually there.
  function automatic logic [POP_W-1:0] sat_pop(input logic [POP_W-1:0] req,
                                               input logic [CNT_W-1:0] occ);
    if (CNT_W'(req) > occ) return POP_W'(occ);
    return req;
  endfunction

  miinst_compactor #(.FET_W(FET_W)) u_compactor (
    .fet_miinst (q.fet_miinst),
    .compacted  (compacted_p0),
    .n_in       (n_in_p0)
  );

  // Stage p0: accept decision from registered count only, so deq_pop never reaches fet_ready.
  assign fet_ready  = (count <= CNT_W'(DEPTH - FET_W));
  assign vld_p0     = q.fet_valid & fet_ready;
  assign eff_pop    = sat_pop(q.deq_pop, count);
  assign count_next = count + (vld_p0 ? CNT_W'(n_in_p0) : CNT_W'(0)) - CNT_W'(eff_pop);

  // Stage p1: control state; flush clears exactly like reset and drops any push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(eff_pop);
      if (vld_p0) tail <= tail + PTR_W'(n_in_p0);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0 && !rst && !flush) begin
      for (int k = 0; k < FET_W; k++) begin
        if (NIN_W'(k) < n_in_p0) mem[tail + PTR_W'(k)] <= compacted_p0[k];
      end
    end
  end

  logic [DEQ_W-1:0]    deq_valid;
  miinst_t [DEQ_W-1:0] deq_miinst;

  always_comb begin
    deq_valid  = '0;
    deq_miinst = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid[i]  = (count > CNT_W'(i));
      deq_miinst[i] = deq_valid[i] ? mem[head + PTR_W'(i)] : miinst_nop();
    end
  end

  assign q.fet_ready  = fet_ready;
  assign q.deq_valid  = deq_valid;
  assign q.deq_miinst = deq_miinst;
  assign q.count      = count;
  assign q.empty      = (count == '0);
  assign q.full       = (count == CNT_W'(DEPTH));

  a_pop_in_range: assert property (@(posedge clk) disable iff (rst || flush)
                                   (CNT_W'(q.deq_pop) <= count));
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                                   (count <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_miinst_queue.sv
// Scenario bench for miinst_queue with a program-order scoreboard of expected dequeues.
module tb_miinst_queue;
  import miinst_queue_pkg::*;

  localparam int FET_W = 4;
  localparam int DEPTH = 16;
  localparam int DEQ_W = 2;
  localparam int POP_W = $clog2(DEQ_W + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  miinst_queue_if #(.FET_W(FET_W), .DEPTH(DEPTH), .DEQ_W(DEQ_W)) q ();

  miinst_queue #(.FET_W(FET_W), .DEPTH(DEPTH), .DEQ_W(DEQ_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (q)
  );

  miinst_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  miinst_t N;

  function automatic miinst_t mk(input int tag);
    miinst_t m;
    m.opcode = miop_e'(4'(1 + (tag % 5)));
    m.rd     = 5'(tag);
    m.rs1    = 5'(tag + 1);
    m.rs2    = 5'(tag + 2);
    m.imm    = 16'(tag);
    return m;
  endfunction

  task automatic drive(input miinst_t a, input miinst_t b, input miinst_t c, input miinst_t d,
                       input logic v, input int pop);
    q.fet_miinst[0] = a;
    q.fet_miinst[1] = b;
    q.fet_miinst[2] = c;
    q.fet_miinst[3] = d;
    q.fet_valid     = v;
    q.deq_pop       = POP_W'(pop);
  endtask

  // One clock: compare popped entries against the scoreboard, then advance the model.
  task automatic tick();
    int  np;
    bit  acc;
    np  = (int'(q.deq_pop) < sb.size()) ? int'(q.deq_pop) : sb.size();
    acc = q.fet_valid && ((DEPTH - sb.size()) >= FET_W);
    if (!rst && !flush) begin
      for (int i = 0; i < np; i++) begin
        n_checks++;
        if (q.deq_miinst[i] !== sb[i]) begin
          n_fail++;
          $display("FAIL sb_pop[%0d] got %h expected %h", i, q.deq_miinst[i], sb[i]);
        end
      end
    end
    @(posedge clk);
    if (rst || flush) begin
      sb.delete();
    end else begin
      for (int i = 0; i < np; i++) void'(sb.pop_front());
      if (acc) begin
        for (int s = 0; s < FET_W; s++)
          if (q.fet_miinst[s].opcode != MIOP_NOP) sb.push_back(q.fet_miinst[s]);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(N, N, N, N, 1'b0, 0);
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (q.count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count got %0d expected 0", q.count); end
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b expected 1", q.empty); end
    n_checks++; if (q.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b expected 0", q.full); end
    n_checks++; if (q.fet_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b expected 1", q.fet_ready); end
    n_checks++; if (q.deq_valid !== 2'b00) begin n_fail++; $display("FAIL reset_deq_valid got %b expected 00", q.deq_valid); end
    for (int i = 0; i < DEQ_W; i++) begin
      n_checks++;
      if (q.deq_miinst[i].opcode !== MIOP_NOP) begin
        n_fail++; $display("FAIL reset_deq_nop[%0d] got %h expected 0", i, q.deq_miinst[i].opcode);
      end
    end
  endtask

  task automatic test_compact();
    drive(mk(1), N, mk(2), mk(3), 1'b1, 0);
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL push_cycle_empty got %b expected 1", q.empty); end
    tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.count !== CNT_W'(3)) begin n_fail++; $display("FAIL compact_count got %0d expected 3", q.count); end
    n_checks++; if (q.deq_valid !== 2'b11) begin n_fail++; $display("FAIL compact_valid got %b expected 11", q.deq_valid); end
    n_checks++; if (q.deq_miinst[0] !== mk(1)) begin n_fail++; $display("FAIL compact_deq0 got %h expected %h", q.deq_miinst[0], mk(1)); end
    n_checks++; if (q.deq_miinst[1] !== mk(2)) begin n_fail++; $display("FAIL compact_deq1 got %h expected %h", q.deq_miinst[1], mk(2)); end
    drive(N, N, N, N, 1'b0, 2);
    tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.deq_miinst[0] !== mk(3)) begin n_fail++; $display("FAIL compact_after_pop got %h expected %h", q.deq_miinst[0], mk(3)); end
    n_checks++; if (q.count !== CNT_W'(1)) begin n_fail++; $display("FAIL compact_count_pop got %0d expected 1", q.count); end
    n_checks++; if (q.deq_valid !== 2'b01) begin n_fail++; $display("FAIL compact_valid_pop got %b expected 01", q.deq_valid); end
    drive(N, N, N, N, 1'b0, 1);
    tick();
    drive(N, N, N, N, 1'b0, 0);
  endtask

  task automatic test_nop_bundle();
    drive(N, N, N, mk(4), 1'b1, 0);
    tick();
    n_checks++; if (q.count !== CNT_W'(1)) begin n_fail++; $display("FAIL nopb_count got %0d expected 1", q.count); end
    n_checks++; if (q.deq_miinst[0] !== mk(4)) begin n_fail++; $display("FAIL nopb_deq0 got %h expected %h", q.deq_miinst[0], mk(4)); end
    drive(N, N, N, N, 1'b1, 0);
    tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.count !== CNT_W'(1)) begin n_fail++; $display("FAIL allnop_count got %0d expected 1", q.count); end
    n_checks++; if (q.fet_ready !== 1'b1) begin n_fail++; $display("FAIL allnop_ready got %b expected 1", q.fet_ready); end
    n_checks++; if (q.deq_miinst[0] !== mk(4)) begin n_fail++; $display("FAIL allnop_deq0 got %h expected %h", q.deq_miinst[0], mk(4)); end
    drive(N, N, N, N, 1'b0, 1);
    tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL nopb_drain_empty got %b expected 1", q.empty); end
  endtask

  task automatic test_full();
    for (int b = 0; b < 4; b++) begin
      drive(mk(10 + 4*b), mk(11 + 4*b), mk(12 + 4*b), mk(13 + 4*b), 1'b1, 0);
      tick();
    end
    drive(mk(90), mk(91), mk(92), mk(93), 1'b1, 0);
    n_checks++; if (q.count !== CNT_W'(16)) begin n_fail++; $display("FAIL full_count got %0d expected 16", q.count); end
    n_checks++; if (q.full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b expected 1", q.full); end
    n_checks++; if (q.fet_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b expected 0", q.fet_ready); end
    tick();
    n_checks++; if (q.count !== CNT_W'(16)) begin n_fail++; $display("FAIL full_refused got %0d expected 16", q.count); end
    drive(mk(90), mk(91), mk(92), mk(93), 1'b1, 2);
    tick();
    n_checks++; if (q.count !== CNT_W'(14)) begin n_fail++; $display("FAIL full_pop14 got %0d expected 14", q.count); end
    n_checks++; if (q.fet_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready14 got %b expected 0", q.fet_ready); end
    drive(N, N, N, N, 1'b0, 2);
    tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.count !== CNT_W'(12)) begin n_fail++; $display("FAIL full_pop12 got %0d expected 12", q.count); end
    n_checks++; if (q.fet_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready12 got %b expected 1", q.fet_ready); end
    n_checks++; if (q.full !== 1'b0) begin n_fail++; $display("FAIL full_flag12 got %b expected 0", q.full); end
    drive(N, N, N, N, 1'b0, 2);
    repeat (6) tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty got %b expected 1", q.empty); end
  endtask

  task automatic test_wrap();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(mk(20 + 4*b), mk(21 + 4*b), mk(22 + 4*b), mk(23 + 4*b), 1'b1, 0);
      tick();
    end
    drive(mk(32), mk(33), N, N, 1'b1, 0);
    tick();
    drive(N, N, N, N, 1'b0, 2);
    repeat (7) tick();
    drive(mk(40), mk(41), mk(42), mk(43), 1'b1, 0);
    n_checks++; if (q.count !== CNT_W'(0)) begin n_fail++; $display("FAIL wrap_pre_count got %0d expected 0", q.count); end
    tick();
    drive(N, N, N, N, 1'b0, 2);
    n_checks++; if (q.count !== CNT_W'(4)) begin n_fail++; $display("FAIL wrap_count got %0d expected 4", q.count); end
    n_checks++; if (q.deq_miinst[0] !== mk(40)) begin n_fail++; $display("FAIL wrap_e got %h expected %h", q.deq_miinst[0], mk(40)); end
    n_checks++; if (q.deq_miinst[1] !== mk(41)) begin n_fail++; $display("FAIL wrap_f got %h expected %h", q.deq_miinst[1], mk(41)); end
    tick();
    n_checks++; if (q.deq_miinst[0] !== mk(42)) begin n_fail++; $display("FAIL wrap_g got %h expected %h", q.deq_miinst[0], mk(42)); end
    n_checks++; if (q.deq_miinst[1] !== mk(43)) begin n_fail++; $display("FAIL wrap_h got %h expected %h", q.deq_miinst[1], mk(43)); end
    tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b expected 1", q.empty); end
  endtask

  task automatic test_simul();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(mk(50), mk(51), mk(52), mk(53), 1'b1, 0);
    tick();
    drive(mk(54), N, N, N, 1'b1, 0);
    tick();
    n_checks++; if (q.count !== CNT_W'(5)) begin n_fail++; $display("FAIL simul_pre got %0d expected 5", q.count); end
    drive(mk(55), N, mk(56), mk(57), 1'b1, 2);
    tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.count !== CNT_W'(6)) begin n_fail++; $display("FAIL simul_count got %0d expected 6", q.count); end
    n_checks++; if (q.deq_miinst[0] !== mk(52)) begin n_fail++; $display("FAIL simul_oldest got %h expected %h", q.deq_miinst[0], mk(52)); end
    drive(N, N, N, N, 1'b0, 2);
    repeat (3) tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty got %b expected 1", q.empty); end
  endtask

  task automatic test_clear(input bit use_rst);
    for (int b = 0; b < 2; b++) begin
      drive(mk(60 + 4*b), mk(61 + 4*b), mk(62 + 4*b), mk(63 + 4*b), 1'b1, 0);
      tick();
    end
    drive(N, mk(68), N, N, 1'b1, 0);
    tick();
    n_checks++; if (q.count !== CNT_W'(9)) begin n_fail++; $display("FAIL clear%0d_pre got %0d expected 9", use_rst, q.count); end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    drive(mk(70), mk(71), mk(72), mk(73), 1'b1, 2);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.count !== CNT_W'(0)) begin n_fail++; $display("FAIL clear%0d_count got %0d expected 0", use_rst, q.count); end
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL clear%0d_empty got %b expected 1", use_rst, q.empty); end
    n_checks++; if (q.deq_valid !== 2'b00) begin n_fail++; $display("FAIL clear%0d_valid got %b expected 00", use_rst, q.deq_valid); end
    n_checks++; if (q.deq_miinst[0].opcode !== MIOP_NOP) begin n_fail++; $display("FAIL clear%0d_nop got %h expected 0", use_rst, q.deq_miinst[0].opcode); end
    tick();
    n_checks++; if (q.count !== CNT_W'(0)) begin n_fail++; $display("FAIL clear%0d_absent got %0d expected 0", use_rst, q.count); end
  endtask

  task automatic test_back_to_back();
    drive(mk(80), mk(81), N, mk(82), 1'b1, 0);
    tick();
    drive(mk(83), mk(84), mk(85), mk(86), 1'b1, 2);
    tick();
    drive(N, mk(87), N, N, 1'b1, 2);
    tick();
    drive(N, N, N, N, 1'b0, 2);
    n_checks++; if (q.count !== CNT_W'(4)) begin n_fail++; $display("FAIL b2b_count got %0d expected 4", q.count); end
    repeat (2) tick();
    drive(N, N, N, N, 1'b0, 0);
    n_checks++; if (q.empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b expected 1", q.empty); end
  endtask

  initial begin
    N = miinst_nop();
    drive(N, N, N, N, 1'b0, 0);
    test_reset();
    test_compact();
    test_nop_bundle();
    test_full();
    test_wrap();
    test_simul();
    test_clear(1'b0);
    test_clear(1'b1);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miinst_queue.md
Name: miinst_queue

Overview:
- Parametrised successor to the single-issue decode queue.
- Circular FIFO of miinst_t between fetch/micro-decode and the issue stage.
- Accepts an FET_W-wide fetch bundle and compacts out every MIOP_NOP slot, interior gaps included.
- Presents up to DEQ_W oldest entries per cycle; the consumer pops 0..DEQ_W of them. Explicit backpressure replaces silent overwrite.

Parameters:
- FET_W, 4: slots per fetch bundle (power of 2, >=1).
- DEPTH, 16: queue entries (power of 2, DEPTH >= FET_W+DEQ_W).
- DEQ_W, 2: entries presented and poppable per cycle (1..DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear (branch mispredict/exception).
- fet_miinst  in  miinst_t[FET_W]  fetch bundle; slot 0 is oldest; opcode==MIOP_NOP means empty slot.
- fet_valid  in  1  bundle present.
- fet_ready  out  1  queue guaranteed to hold a full bundle.
- deq_miinst  out  miinst_t[DEQ_W]  oldest entries; index 0 is oldest.
- deq_valid  out  DEQ_W  thermometer mask; bit i set iff count > i.
- deq_pop  in  $clog2(DEQ_W+1)  entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- State: storage array, head and tail pointers ($clog2(DEPTH) bits, wrap mod DEPTH), registered count.
- Reset: rst=1 at a clock edge sets head=tail=0 and count=0. Outputs are then fet_ready=1, deq_valid=0, empty=1, full=0, and every deq_miinst opcode reads MIOP_NOP. Storage contents are not cleared.
- flush: same effect as rst. Priority is rst = flush > push/pop; a push or pop in the same cycle is discarded.
- fet_ready = (DEPTH - count) >= FET_W.
  - Computed from registered count only; it does not depend on deq_pop, so there is no combinational path from the consumer.
- Push: occurs when fet_valid & fet_ready.
  - n_in = number of non-NOP slots.
  - The k-th non-NOP slot, in ascending slot order, is written to storage[(tail+k) mod DEPTH].
  - tail advances by n_in.
  - An all-NOP bundle is accepted with n_in=0 and changes no state.
- fet_valid & ~fet_ready: bundle not taken; the producer must hold it.
- Pop: eff_pop = min(deq_pop, count); head advances by eff_pop.
  - deq_pop > count is a protocol violation. Clamp it and fire a simulation assertion.
- Simultaneous push and pop: count_next = count + n_in - eff_pop.
  - Push ordering is independent of the pop.
  - Storage slots freed by the pop are not reusable until the next cycle.
- Latency: a pushed entry is visible on deq_miinst one cycle after the accepting edge. There is no same-cycle bypass; empty stays 1 in the push cycle.
- deq_miinst[i] = storage[(head+i) mod DEPTH] when deq_valid[i]; otherwise opcode forced to MIOP_NOP. All other fields are don't-care.
- Wrap-around: pointer arithmetic uses modulo DEPTH. A write or read run crossing index DEPTH-1 -> 0 must be seamless.
- Order: global program order is preserved across bundles and within a bundle.
- Invariant: 0 <= count <= DEPTH. Overflow is impossible by construction of fet_ready; add an assertion.

Decomposition:
- Shared package (common_params.h), already holding miinst_t and MIOP_NOP. Add:
  - default macros `MIQ_FET_W, `MIQ_DEPTH, `MIQ_DEQ_W
  - their _W log2 companions
- Sub-module miinst_compactor (combinational):
  - inputs: fet_miinst[FET_W]
  - outputs: compacted miinst_t[FET_W], n_in
  - uses a prefix popcount of non-NOP flags
- The queue instantiates the compactor and writes compacted[0..n_in-1] starting at tail.

Test Plan:
- Reset then push bundle {A,NOP,B,C} -> next cycle count=3, deq_valid=2'b11, deq_miinst={A,B}; pop 2 -> next cycle deq_miinst[0]=C, count=1.
- Bundle {NOP,NOP,NOP,D} with an empty queue -> count=1, deq_miinst[0]=D; all-NOP bundle -> state unchanged, fet_ready stays 1.
- Fill with four full bundles (count=16), no pops -> fet_ready=0, full=1. Offered bundle not taken. Pop 2 -> fet_ready still 0 (count=14 > 12 free threshold). Pop to 12 -> fet_ready=1.
- Wrap: advance head/tail to 14, push {E,F,G,H} -> entries at 14,15,0,1. Four pops over two cycles return E,F,G,H in order.
- Simultaneous: count=5, push 3 non-NOP, deq_pop=2 -> count=6, and the oldest remaining entry is the third-oldest original.
- flush asserted with fet_valid=1, deq_pop=2, count=9 -> next cycle count=0, empty=1, deq_valid=0, pushed bundle absent. Same check for rst mid-stream.
